wb_ram_burst: RTL and testbench
===============================

Name: wb_ram_burst

Overview:
Parametrised Wishbone B4 single-port RAM slave. It generalises the fixed 32-bit classic-cycle RAM slave to configurable data width, depth and base address. It adds registered-feedback incrementing bursts (CTI/BTE with linear and wrap4/8/16 modes), byte-lane writes and an error response for out-of-range addresses. It sits on a NoC/interconnect slave port as local data or instruction memory for the RV32I cores.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8, minimum 8.
ADDR_W, 32, Wishbone byte-address width.
MEM_WORDS, 1024, depth in DATA_W-bit words; power of 2.
BASE_ADDR, 32'h0000_0000, byte base address; aligned to MEM_WORDS*DATA_W/8.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
rst_i  in  1  synchronous active-high reset.
wb_adr_i  in  ADDR_W  byte address.
wb_dat_i  in  DATA_W  write data.
wb_sel_i  in  DATA_W/8  byte-lane enables.
wb_we_i  in  1  1 = write, 0 = read.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe.
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as classic.
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
wb_dat_o  out  DATA_W  registered read data.
wb_ack_o  out  1  registered acknowledge.
wb_err_o  out  1  registered error; mutually exclusive with ack.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM in IDLE. Memory contents are not cleared.
- Reset mid-operation: the FSM returns to IDLE and ack/err go low at the next edge. No write commits in the reset cycle.
- Word index: idx = (wb_adr_i - BASE_ADDR) >> log2(DATA_W/8). Low byte-offset bits are ignored.
- In range: BASE_ADDR <= wb_adr_i < BASE_ADDR + MEM_WORDS*DATA_W/8.
- RAM read timing: synchronous read, issued in the cycle before the response.
- Responses: ack/err are registered. wb_dat_o updates only on read-ack beats and holds otherwise. On err, wb_dat_o=0.
- Write commit: writes commit at the clock edge closing a cycle where wb_ack_o=1 & cyc & stb & we. Address, data and sel are sampled in that cycle. Only lanes with sel=1 are written.
- Error beats: never write.
- FSM states: IDLE, CLASSIC, BURST.
- IDLE: when cyc&stb, issue a read of idx. Next cycle, raise ack (in range) or err (out of range).
  - Go to BURST if cti=010 and the address is in range.
  - Otherwise go to CLASSIC.
- CLASSIC:
  - ack/err is high for exactly one cycle, then the FSM returns to IDLE with ack/err low.
  - A request held across the ack cycle is not re-accepted until IDLE.
  - Throughput is one transfer per 2 cycles.
- BURST, beat cycle (ack=1, cyc&stb):
  - If cti=111, this is the last beat; next state is IDLE and ack drops.
  - If cti=010, compute the predicted next index pidx and read it in the same cycle.
  - Predicted-index rule: linear gives idx+1; wrapN increments idx[log2N-1:0] modulo N and keeps the upper bits.
  - Next cycle, if the master's wb_adr_i index equals pidx, ack=1 again. This gives one beat per cycle.
  - If pidx falls out of range (linear past the last word), respond with err instead of ack and return to IDLE after that beat.
- BURST, address mismatch (master address differs from pidx):
  - Hold ack=0 for one cycle and re-read the master's index.
  - Respond the following cycle, costing one wait state.
- BURST, stb low with cyc high: ack=0, go to IDLE. A subsequent strobe restarts as a new access.
- cyc low in any state: next state is IDLE, ack/err=0, no write.
- Read data: no read-during-write forwarding is needed. Burst reads never target the index written in the same cycle; classic accesses are separated by IDLE.

Test Plan:
Parameters for all tests: DATA_W=32, MEM_WORDS=256, BASE_ADDR=0x1000.
1. Reset: hold rst_i 2 cycles with cyc=stb=1 -> ack=err=0, dat_o=0 throughout, no write occurs.
2. Classic write then read:
   - Write 0xDEADBEEF to 0x1008 with sel=1111 -> ack high exactly 1 cycle, one cycle after stb.
   - Classic read of 0x1008 -> ack one cycle after stb, dat_o=0xDEADBEEF.
3. Byte write: write 0x0000AA00 to 0x1008 with sel=0010 -> read returns 0xDEADAAEF.
4. Wrap4 read burst:
   - Preload idx4..7 with 0x44, 0x55, 0x66, 0x77.
   - Run cti=010, bte=01, starting at 0x1018, with the master supplying the correct addresses, and cti=111 on the 4th beat.
   - Required: ack high 4 consecutive cycles, dat_o = 0x66, 0x77, 0x44, 0x55, then ack=0.
5. Error cases:
   - Classic write to 0x1400 -> err 1 cycle, ack=0, memory unchanged.
   - Linear read burst from 0x13F8 -> ack on idx254 and idx255, then err on the third beat, then IDLE.
6. Burst disruption:
   - Master skips an address mid-linear-burst -> one cycle with ack=0, then ack with the correct data.
   - Separately, drop cyc mid-write-burst -> ack=0 next cycle; the beat in flight is not written.

Source files
------------

// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone B4 RAM slave with byte lanes, CTI/BTE bursts and range error
// Registered ack/err; burst beats are acked on a predicted index and re-read on a master skip.
module wb_ram_burst #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(MEM_WORDS * NB);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_t;

  state_t            r_state;
  logic              r_ack;
  logic              r_err;
  logic              r_chk;
  logic [IW-1:0]     r_pidx;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic [ADDR_W-1:0] w_off;
  logic              w_in_range;
  logic              w_req;
  logic              w_match;
  logic              w_wr;
  logic              w_pidx_ok;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_mask;
  logic [IW-1:0]     w_pidx;
  logic [IW-1:0]     w_rd_idx;
  logic [IW:0]       w_inc;

  assign w_off      = wb_adr_i - BASE_ADDR;
  assign w_in_range = (wb_adr_i >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[OFF_W +: IW];
  assign w_req      = wb_cyc_i & wb_stb_i;

  always_comb begin
    w_mask = '0;
    case (wb_bte_i)
      2'b01:   w_mask = IW'(3);
      2'b10:   w_mask = IW'(7);
      2'b11:   w_mask = IW'(15);
      default: w_mask = '0;
    endcase
  end

  // Linear bursts carry into bit IW when they run off the end; wrap bursts never leave range.
  assign w_inc     = {1'b0, w_idx} + (IW+1)'(1);
  assign w_pidx    = (w_mask == '0) ? w_inc[IW-1:0]
                                    : ((w_idx & ~w_mask) | (w_inc[IW-1:0] & w_mask));
  assign w_pidx_ok = (w_mask != '0) | ~w_inc[IW];

  // A predicted beat is only acked if the master actually presents the predicted index.
  assign w_match  = w_in_range && (w_idx == r_pidx);
  assign wb_ack_o = r_ack & (~r_chk | w_match);
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;

  assign w_wr     = wb_ack_o & w_req & wb_we_i & w_in_range & ~rst_i;
  assign w_rd_idx = (r_state == S_BURST && wb_ack_o) ? w_pidx : w_idx;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) r_mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_chk   <= 1'b0;
      r_pidx  <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_chk   <= 1'b0;
      if (w_req) begin
        case (r_state)
          S_IDLE: begin
            r_ack <= w_in_range;
            r_err <= ~w_in_range;
            if (!w_in_range)   r_dat <= '0;
            else if (!wb_we_i) r_dat <= r_mem[w_rd_idx];
            r_state <= (wb_cti_i == CTI_INC && w_in_range) ? S_BURST : S_CLASSIC;
          end
          S_BURST: begin
            if (wb_ack_o) begin
              if (wb_cti_i == CTI_INC) begin
                r_state <= S_BURST;
                r_pidx  <= w_pidx;
                r_chk   <= 1'b1;
                r_ack   <= w_pidx_ok;
                r_err   <= ~w_pidx_ok;
                if (!w_pidx_ok)    r_dat <= '0;
                else if (!wb_we_i) r_dat <= r_mem[w_rd_idx];
              end
            end else if (r_ack) begin
              r_state <= S_BURST;
              r_ack   <= w_in_range;
              r_err   <= ~w_in_range;
              if (!w_in_range)   r_dat <= '0;
              else if (!wb_we_i) r_dat <= r_mem[w_rd_idx];
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - directed bench for wb_ram_burst with a response scoreboard
// Each cycle pushes its expected response, then pops and compares at the falling edge.
module tb_wb_ram_burst;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          WORDS = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  always #5 clk = ~clk;

  wb_ram_burst #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o)
  );

  typedef struct {
    string       tag;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        chk_dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_hold = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] adr, input logic cyc, input logic stb,
                      input logic we, input logic [31:0] wd, input logic [3:0] sel,
                      input logic [2:0] cti, input logic [1:0] bte, input logic eack, input logic eerr);
    exp_t e;
    exp_t got;
    int   idx;
    idx = int'((adr - BASE) >> 2) & (WORDS - 1);
    wb_adr_i = adr; wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we;
    wb_dat_i = wd;  wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
    e.tag = tag; e.ack = eack; e.err = eerr; e.chk_dat = 1'b1; e.dat = '0;
    if (eerr)             e.dat = '0;
    else if (eack && !we) e.dat = ref_mem[idx];
    else if (eack)        e.dat = exp_hold;
    else if (rst_i)       e.dat = '0;
    else                  e.chk_dat = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk(got.tag, "ack", 32'(wb_ack_o), 32'(got.ack));
    chk(got.tag, "err", 32'(wb_err_o), 32'(got.err));
    if (got.chk_dat) chk(got.tag, "dat", wb_dat_o, got.dat);
    if (eack && we && cyc && stb && !rst_i) begin
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    if (rst_i || eerr)    exp_hold = '0;
    else if (eack && !we) exp_hold = ref_mem[idx];
    @(posedge clk); #1;
  endtask

  task automatic classic(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] wd, input logic [3:0] sel);
    logic inr;
    inr = (adr >= BASE) && (adr < BASE + 32'(WORDS * 4));
    beat($sformatf("%s/req", tag), adr, 1'b1, 1'b1, we, wd, sel, 3'b000, 2'b00, 1'b0, 1'b0);
    beat($sformatf("%s/rsp", tag), adr, 1'b1, 1'b1, we, wd, sel, 3'b000, 2'b00, inr, !inr);
    beat($sformatf("%s/end", tag), adr, 1'b0, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst_i = 1'b1; wb_adr_i = BASE; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    @(posedge clk); #1;
    beat("rst0", BASE, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    beat("rst1", BASE, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b0;

    classic("wr1008", 32'h1008, 1'b1, 32'hDEAD_BEEF, 4'hF);
    classic("rd1008", 32'h1008, 1'b0, '0, 4'h0);
    classic("byte1008", 32'h1008, 1'b1, 32'h0000_AA00, 4'b0010);
    classic("rdbyte", 32'h1008, 1'b0, '0, 4'h0);

    // Reset lands on the ack cycle of a write: that write must not commit.
    classic("wr1000", 32'h1000, 1'b1, 32'hCAFE_F00D, 4'hF);
    beat("rmid/req", 32'h1000, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b1;
    beat("rmid/ack", 32'h1000, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0);
    beat("rmid/rst", 32'h1000, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    rst_i = 1'b0;
    beat("rmid/rel", 32'h1000, 1'b0, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
    classic("rmid/rd", 32'h1000, 1'b0, '0, 4'h0);

    classic("pre4", 32'h1010, 1'b1, 32'h44, 4'hF);
    classic("pre5", 32'h1014, 1'b1, 32'h55, 4'hF);
    classic("pre6", 32'h1018, 1'b1, 32'h66, 4'hF);
    classic("pre7", 32'h101C, 1'b1, 32'h77, 4'hF);
    beat("w4/req", 32'h1018, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b01, 1'b0, 1'b0);
    idx = 6;
    for (int n = 0; n < 4; n++) begin
      beat($sformatf("w4/beat%0d", n), BASE + 32'(idx * 4), 1'b1, 1'b1, 1'b0, '0, 4'h0,
           (n == 3) ? 3'b111 : 3'b010, 2'b01, 1'b1, 1'b0);
      idx = (idx & ~3) | ((idx + 1) & 3);
    end
    beat("w4/end", 32'h1014, 1'b0, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
    chk("w4", "order", exp_hold, 32'h55);

    classic("oob_wr", 32'h1400, 1'b1, 32'hBADB_AD00, 4'hF);
    classic("oob_chk", 32'h1000, 1'b0, '0, 4'h0);

    classic("pre254", 32'h13F8, 1'b1, 32'hA5A5_00FE, 4'hF);
    classic("pre255", 32'h13FC, 1'b1, 32'hA5A5_00FF, 4'hF);
    beat("lin/req", 32'h13F8, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b0, 1'b0);
    beat("lin/b254", 32'h13F8, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("lin/b255", 32'h13FC, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("lin/err", 32'h1400, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b0, 1'b1);
    beat("lin/idle", 32'h1400, 1'b1, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
    classic("lin/again", 32'h13FC, 1'b0, '0, 4'h0);

    for (int i = 16; i <= 20; i++)
      classic($sformatf("pre%0d", i), BASE + 32'(i * 4), 1'b1, 32'h1000_0000 | 32'(i), 4'hF);
    beat("skip/req", 32'h1040, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b0, 1'b0);
    beat("skip/b16", 32'h1040, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("skip/b17", 32'h1044, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("skip/wait", 32'h104C, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b0, 1'b0);
    beat("skip/b19", 32'h104C, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("skip/b20", 32'h1050, 1'b1, 1'b1, 1'b0, '0, 4'h0, 3'b111, 2'b00, 1'b1, 1'b0);
    beat("skip/end", 32'h1050, 1'b0, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);

    for (int i = 32; i <= 34; i++)
      classic($sformatf("old%0d", i), BASE + 32'(i * 4), 1'b1, 32'h0BAD_0000 | 32'(i), 4'hF);
    beat("drop/req", 32'h1080, 1'b1, 1'b1, 1'b1, 32'h5EED_0020, 4'hF, 3'b010, 2'b00, 1'b0, 1'b0);
    beat("drop/b32", 32'h1080, 1'b1, 1'b1, 1'b1, 32'h5EED_0020, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0);
    beat("drop/b33", 32'h1084, 1'b1, 1'b1, 1'b1, 32'h5EED_0021, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0);
    wb_adr_i = 32'h1088; wb_dat_i = 32'h5EED_0022; wb_cyc_i = 1'b0; wb_stb_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    beat("drop/after", 32'h1088, 1'b0, 1'b0, 1'b0, '0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
    classic("drop/rd32", 32'h1080, 1'b0, '0, 4'h0);
    classic("drop/rd33", 32'h1084, 1'b0, '0, 4'h0);
    classic("drop/rd34", 32'h1088, 1'b0, '0, 4'h0);
    chk("drop", "old34", exp_hold, 32'h0BAD_0022);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
